// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; optional MULDIV_ZERO_BYPASS_EN skips trivial operands
module muldiv_sequencer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cancel,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [N-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
  state_t state, state_nx;
  logic is_div, neg_q, neg_r, abort, launch, sa, sb, skip;
  logic [CW-1:0] cnt;
  logic [N-1:0] acc, wrk, opb, ma, mb, hi_res, lo_res;
  logic [N+1:0] lhs, rhs, res;
  logic [2*N-1:0] prod_n;
  assign busy   = state == CALC || state == SIGN;
  assign done   = state == DONE;
  assign abort  = busy && (cancel || hi_we || lo_we);
  assign launch = state == IDLE && start;
  assign sa     = op[0] & a[N-1];
  assign sb     = op[0] & b[N-1];
  assign ma     = sa ? -a : a;
  assign mb     = sb ? -b : b;
`ifdef MULDIV_ZERO_BYPASS_EN
  assign skip   = b == '0 || (!op[1] && a == '0);
`else
  assign skip   = 1'b0;
`endif
  // Shared add/sub: multiply adds the multiplicand when mplr[0]; divide trial-subtracts from the shifted remainder
  assign lhs    = is_div ? {1'b0, acc, wrk[N-1]} : {2'b00, acc};
  assign rhs    = (is_div || wrk[0]) ? {2'b00, opb} : '0;
  assign res    = lhs + (is_div ? ~rhs : rhs) + {{(N+1){1'b0}}, is_div};
  assign prod_n = -{acc, wrk};
  assign hi_res = is_div ? (neg_r ? -acc : acc) : (neg_q ? prod_n[2*N-1:N] : acc);
  assign lo_res = neg_q ? (is_div ? -wrk : prod_n[N-1:0]) : wrk;
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Next-state: launch, abort on cancel/MTHI/MTLO while busy, N iterations, sign fix, done pulse
  always_comb begin
    state_nx = state;
    if (launch) state_nx = skip ? DONE : CALC;
    else if (abort) state_nx = IDLE;
    else if (state == CALC && cnt == CW'(N-1)) state_nx = SIGN;
    else if (state == SIGN) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end
  // Working registers plus architectural HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      wrk    <= '0;
      opb    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (launch) begin
        is_div <= op[1];
        neg_q  <= (sa ^ sb) & ~(op[1] & (b == '0));
        neg_r  <= sa;
        cnt    <= '0;
        acc    <= '0;
        wrk    <= op[1] ? ma : mb;
        opb    <= op[1] ? mb : ma;
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
        if (is_div) begin
          acc <= res[N+1] ? {acc[N-2:0], wrk[N-1]} : res[N-1:0];
          wrk <= {wrk[N-2:0], ~res[N+1]};
        end else
          {acc, wrk} <= {res[N:0], wrk[N-1:1]};
      end
      if (state == SIGN && !abort) begin
        hi <= hi_res;
        lo <= lo_res;
      end else if (state != DONE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
`ifdef MULDIV_ZERO_BYPASS_EN
      if (launch && skip) begin
        hi <= op[1] ? a : '0;
        lo <= op[1] ? '1 : '0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for muldiv_sequencer against an arithmetic reference model
module tb_muldiv_sequencer;
  localparam int N = 32;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cancel = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0] op = 2'b00;
  logic [N-1:0] a = '0, b = '0, wdata = '0;
  logic busy, done;
  logic [N-1:0] hi, lo;
  int tests = 0, fails = 0, cyc = 0;
  typedef struct { logic [31:0] hi; logic [31:0] lo; int cyc; } exp_t;
  exp_t sb[$];

  muldiv_sequencer #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    if (o == 2'd0) return {32'b0, x} * {32'b0, y};
    if (o == 2'd1) return $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
    if (y == 0) return {x, 32'hFFFF_FFFF};
    if (o == 2'd2) return {x % y, x / y};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int latency(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef MULDIV_ZERO_BYPASS_EN
    if (y == 0 || (!o[1] && x == 0)) return 1;
`endif
    return N + 1;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation, including its timing
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_hi", 64'(hi), 64'(e.hi));
        chk("result_lo", 64'(lo), 64'(e.lo));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit expect_it);
    exp_t e;
    logic [63:0] m;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    if (expect_it) begin
      m = model(o, x, y);
      e.hi = m[63:32];
      e.lo = m[31:0];
      e.cyc = cyc + latency(o, x, y);
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(output int bc);
    bit got = 0;
    bc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin got = 1; break; end
    end
    chk("done_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int bc);
    issue(o, x, y, 1);
    wait_done(bc);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    logic [31:0] sh, sl, x, y;
    logic [1:0] o;
    #1;
    chk("reset_hi", 64'(hi), 0);
    chk("reset_lo", 64'(lo), 0);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_done", 64'(done), 0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    run(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc);
    chk("tp_multu_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    chk("tp_multu_lo", 64'(lo), 64'h1);
    chk("tp_multu_busy_cycles", 64'(bc), 64'(N + 1));
    run(2'd1, 32'hFFFF_FFFD, 32'd5, bc);
    chk("tp_mult_neg", {32'b0, hi} << 32 | 64'(lo), 64'hFFFF_FFFF_FFFF_FFF1);
    run(2'd1, 32'h8000_0000, 32'h8000_0000, bc);
    chk("tp_mult_min", {32'b0, hi} << 32 | 64'(lo), 64'h4000_0000_0000_0000);
    run(2'd2, 32'd100, 32'd7, bc);
    chk("tp_divu", {32'b0, hi} << 32 | 64'(lo), {32'd2, 32'd14});
    run(2'd3, 32'hFFFF_FFF9, 32'd2, bc);
    chk("tp_div_negnum", {32'b0, hi} << 32 | 64'(lo), 64'hFFFF_FFFF_FFFF_FFFD);
    run(2'd3, 32'd7, 32'hFFFF_FFFE, bc);
    chk("tp_div_negden", {32'b0, hi} << 32 | 64'(lo), 64'h0000_0001_FFFF_FFFD);
    run(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, bc);
    chk("tp_div_ovf", {32'b0, hi} << 32 | 64'(lo), 64'h0000_0000_8000_0000);
    run(2'd2, 32'd5, 32'd0, bc);
    chk("tp_div0", {32'b0, hi} << 32 | 64'(lo), 64'h0000_0005_FFFF_FFFF);
    run(2'd3, 32'hFFFF_FFF0, 32'd0, bc);
    run(2'd0, 32'd0, 32'd12345, bc);
    // A start presented mid-operation must be ignored
    issue(2'd0, 32'd7, 32'd9, 1);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; op = 2'd2; a = 32'd1; b = 32'd1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(bc);
    chk("ignored_start_lo", 64'(lo), 64'd63);
    // Cancel mid-operation: no done, HI/LO retained
    sh = hi; sl = lo;
    issue(2'd0, 32'd3, 32'd4, 0);
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1 cancel = 1'b0;
    @(negedge clk);
    chk("cancel_busy", 64'(busy), 0);
    repeat (40) @(negedge clk);
    chk("cancel_hi", 64'(hi), 64'(sh));
    chk("cancel_lo", 64'(lo), 64'(sl));
    @(posedge clk); #1;
    // Asynchronous reset mid-divide
    issue(2'd2, 32'd1000, 32'd3, 0);
    repeat (14) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_hi", 64'(hi), 0);
    chk("async_rst_lo", 64'(lo), 0);
    chk("async_rst_busy", 64'(busy), 0);
    chk("async_rst_done", 64'(done), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    // MTLO in IDLE
    lo_we = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1 lo_we = 1'b0;
    chk("mtlo_idle", 64'(lo), 64'h1234);
    chk("mtlo_keeps_hi", 64'(hi), 0);
    // MTHI while busy aborts the op and still writes
    issue(2'd1, 32'd11, 32'd13, 0);
    repeat (4) @(posedge clk);
    #1 hi_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(posedge clk); #1 hi_we = 1'b0;
    @(negedge clk);
    chk("mthi_busy_abort", 64'(busy), 0);
    chk("mthi_busy_hi", 64'(hi), 64'hCAFE_F00D);
    chk("mthi_busy_lo", 64'(lo), 64'h1234);
    repeat (40) @(negedge clk);
    @(posedge clk); #1;
    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 9));
        2: x = 32'd0;
        3: x = 32'h8000_0000;
        default: ;
      endcase
      run(o, x, y, bc);
    end
    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit for the MIPS core (MULT, MULTU, DIV, DIVU).
- Sequences one shared N-bit add/sub datapath over N cycles, one bit per cycle, and owns the architectural HI/LO registers.
- Sits beside the execute-stage ALU. The pipeline stalls on busy and reads hi/lo for MFHI/MFLO.

Parameters:
N, 32, operand width and width of HI and LO.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  launch operation; accepted only in IDLE
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a  input  N  multiplicand / dividend
b  input  N  multiplier / divisor
cancel  input  1  abort the in-flight operation
hi_we  input  1  MTHI write strobe
lo_we  input  1  MTLO write strobe
wdata  input  N  MTHI/MTLO data
busy  output  1  operation in flight; stall
done  output  1  one-cycle pulse when hi/lo were updated by an operation
hi  output  N  HI register (product high word / remainder)
lo  output  N  LO register (product low word / quotient)

Behaviour:
- Reset: rst_n low asynchronously sets state=IDLE and busy=0, done=0, hi=0, lo=0, clearing all internal registers. This applies mid-operation too.
- States and transitions:
  - IDLE: start=1 latches op, |a|, |b| and the sign flags, sets cnt=0, and moves to CALC.
  - CALC: N cycles, cnt 0..N-1, then moves to SIGN.
  - SIGN: negates the results when required and writes hi/lo, then moves to DONE.
  - DONE: done=1 for exactly one cycle, then returns to IDLE.
- busy=1 in CALC and SIGN; busy=0 in IDLE and DONE.
- Latency: with start sampled at edge t, hi/lo are written at edge t+N+1 and done is high in the cycle following that edge, i.e. N+2 cycles after start.
- start while busy=1, or in DONE, is ignored. Back-to-back operation: start may be asserted in the DONE cycle is ignored; earliest restart is the next IDLE cycle.
- Signed ops (op[0]=1): operands are converted to magnitudes at launch.
  - Product is negated if a[N-1]^b[N-1].
  - Quotient is negated if a[N-1]^b[N-1]; remainder is negated if a[N-1] (remainder takes the dividend's sign).
  - Magnitude of the most negative value is 2^(N-1) unsigned. No special case: DIV 0x80000000 / -1 yields lo=0x80000000, hi=0.
- Multiply, per CALC cycle, on the {acc, mplr} 2N-bit register:
  - If mplr[0], {c, sum} = acc + mcand; otherwise {c, sum} = {0, acc}.
  - Then {acc, mplr} <= {c, sum, mplr[N-1:1]}.
  - Final hi=acc, lo=mplr.
- Divide, per CALC cycle (restoring division), on the {rem, quo} register:
  - Shift {rem, quo} left by 1, then {borrow, diff} = rem_shifted - divisor, using an N+1-bit compare.
  - If no borrow: rem=diff and quo[0]=1; otherwise rem is kept and quo[0]=0.
  - Final hi=rem, lo=quo.
- Datapath: exactly one N-bit adder/subtractor instance plus one negation path for the SIGN stage/launch. Subtract select is driven by op[1].
- Divide by zero (b=0, DIV or DIVU): lo=all ones, hi=a as presented at launch. No sign fix applies. Latency is the normal latency unless the optional feature is enabled.
- cancel=1 while busy=1: the next state is IDLE, hi/lo are unchanged and done is not pulsed. cancel in IDLE or DONE has no effect.
- hi_we/lo_we:
  - Write wdata to hi/lo on that edge when busy=0.
  - When busy=1, a write also aborts the operation, exactly as cancel does, and the write takes effect.
  - In the DONE cycle the write is ignored because the result was already written.
- Simultaneous start and hi_we/lo_we in IDLE: the write is performed and the start is also accepted.

Optional Feature:
- Macro: MULDIV_ZERO_BYPASS_EN.
- When defined, if b==0 at launch (any op), or a==0 for MULT/MULTU, the sequencer skips CALC and SIGN. At the next edge it writes the result and enters DONE; done pulses 2 cycles after start.
- Bypass results: multiply gives hi=lo=0; divide by zero gives lo=all ones, hi=a; DIV/DIVU with a==0 still runs full latency.
- When undefined, every operation takes N+2 cycles. Results are identical in both builds.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. done exactly 34 cycles after start; busy high 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
- DIVU 100/7 -> lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5. done at 34 cycles, or at 2 cycles with MULDIV_ZERO_BYPASS_EN.
- Start MULTU 3×4, pulse cancel at cycle 10 -> busy=0 next cycle, no done, hi/lo retain prior values. start asserted at cycle 5 of an in-flight op is ignored.
- rst_n low at cycle 15 of DIVU -> hi=lo=0 and busy=done=0 immediately. MTLO 0x1234 in IDLE -> lo=0x1234 next cycle. MTHI during busy -> op aborted, hi=wdata.
